digests_responder: RTL and testbench
====================================

DIGESTS_RESPONDER -- requirements
Module: digests_responder

Interface
REQ-001 Parameter NUM_SLOTS, default 8, number of certificate-chain slots (1..8).
REQ-002 Parameter DIGEST_BYTES, default 32, bytes per slot digest (SHA-256), power of two, 4..64.
REQ-003 Parameter PROTOCOL_VER, default 8'h01, value of header byte 0.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  GET_DIGESTS request decoded upstream.
REQ-007 req_ready  out  1  high only in IDLE.
REQ-008 slots_provisioned  in  NUM_SLOTS  bitmask of slots holding a valid digest.
REQ-009 dig_wr_en  in  1  digest-store byte write strobe.
REQ-010 dig_wr_slot  in  3  slot index of write.
REQ-011 dig_wr_addr  in  $clog2(DIGEST_BYTES)  byte index within slot.
REQ-012 dig_wr_data  in  8  write byte.
REQ-013 tx_data  out  8  response byte.
REQ-014 tx_valid  out  1  tx_data valid.
REQ-015 tx_ready  in  1  downstream accepts byte.
REQ-016 tx_last  out  1  marks final response byte.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 Ack_out  out  1  one-cycle pulse after final byte accepted.

Function
REQ-019 FSM states IDLE, HDR, DIGEST, DONE; a byte transfers when tx_valid && tx_ready.
REQ-020 IDLE: req_valid && req_ready -> latch mask = slots_provisioned into mask_q, go HDR next cycle; tx_valid low.
REQ-021 HDR emits 4 bytes in order: PROTOCOL_VER, 8'h01 (DIGESTS), 8'h00 (Param1), mask_q zero-extended to 8 bits (Param2).
REQ-022 After header byte 3: mask_q nonzero -> DIGEST; mask_q zero -> DONE, tx_last asserted with byte 3.
REQ-023 DIGEST emits, for each set bit of mask_q in ascending slot order, bytes addr 0..DIGEST_BYTES-1 of that slot; unset slots skipped with no idle cycle.
REQ-024 Total bytes = 4 + popcount(mask_q)*DIGEST_BYTES; tx_last high only with the final byte.
REQ-025 tx_valid stays high back-to-back through a response; tx_data/tx_last held stable while tx_valid && !tx_ready.
REQ-026 DONE: Ack_out = 1 for exactly one cycle, then IDLE; earliest next request acceptance is the cycle after DONE.
REQ-027 req_valid while busy is ignored, not queued.
REQ-028 Digest writes accepted only when busy = 0; writes while busy dropped, so transmitted data is frozen per response.
REQ-029 dig_wr_slot >= NUM_SLOTS: write dropped.
REQ-030 slots_provisioned changes after acceptance do not affect the response in progress.
REQ-031 Slot/byte counters wrap to 0 on completion; no counter overflows for any legal parameter set.

Reset
REQ-032 reset asserted at any time (including mid-response) forces IDLE within the same cycle, abandoning the frame.
REQ-033 Reset values: tx_data = 0, tx_valid = 0, tx_last = 0, busy = 0, Ack_out = 0, req_ready = 1 after release, mask_q = 0, digest store all 8'h00.

Configuration
REQ-034 Macro DIGESTS_ERR_RESP_EN: when defined, a request accepted with mask_q = 0 emits a 4-byte ERROR frame (PROTOCOL_VER, 8'h7F, 8'h01 InvalidRequest, 8'h00) with tx_last on byte 3, then DONE.
REQ-035 Without DIGESTS_ERR_RESP_EN, a zero mask produces the header-only DIGESTS frame of REQ-022.

Structure
REQ-036 Shared auth_defs include holds DIGESTS_CMD 8'h01, ERROR_CMD 8'h7F, ERR_INVALID_REQUEST 8'h01, header length 4, FSM state encodings.
REQ-037 Digest storage is sub-module digest_store (NUM_SLOTS x DIGEST_BYTES byte array, synchronous write, combinational read by slot/addr).

Verification
REQ-038 Load slot0 bytes 8'h00..8'h1F, slot2 bytes 8'hA0..8'hBF, provisioned = 8'b0000_0101, pulse req_valid, tx_ready = 1 -> 68 bytes: 01 01 00 05, 00..1F, A0..BF; tx_last on byte 67; Ack_out pulse next cycle.
REQ-039 Same as REQ-038 with tx_ready toggled 1/0 each cycle -> identical byte sequence, tx_data stable during stalls.
REQ-040 provisioned = 0 -> 4 bytes 01 01 00 00 without macro; 01 7F 01 00 with DIGESTS_ERR_RESP_EN.
REQ-041 Assert reset at byte 20 of REQ-038 response -> tx_valid = 0 and busy = 0 immediately; new request yields full correct 68-byte frame.
REQ-042 Write slot0 addr 0 = 8'hFF and change provisioned to 8'hFF while busy -> current frame unchanged; next frame keeps slot0 byte 0 = 8'h00.
REQ-043 req_valid held high continuously -> frames back-to-back, exactly one Ack_out per frame, no request accepted while busy.

Source files
------------

// File: rtl/digests_responder_pkg.sv
// Shared definitions for the GET_DIGESTS responder: opcodes, header length,
// FSM state encodings and the slot-scan helper.
package digests_responder_pkg;

  localparam logic [7:0] DIGESTS_CMD         = 8'h01;
  localparam logic [7:0] ERROR_CMD           = 8'h7F;
  localparam logic [7:0] ERR_INVALID_REQUEST = 8'h01;
  localparam int         HDR_LEN             = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HDR    = 2'd1,
    ST_DIGEST = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Lowest set bit of m at index >= from; returns 8 when none is set.
  function automatic logic [3:0] first_set_from(
    input logic [7:0] m,
    input logic [3:0] from
  );
    logic [3:0] r;
    r = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/digests_responder_store.sv
// Per-slot digest byte array: synchronous write, combinational read.
module digest_store #(
  parameter int NUM_SLOTS    = 8,
  parameter int DIGEST_BYTES = 32,
  localparam int AW          = $clog2(DIGEST_BYTES)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [2:0]    i_wr_slot,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [2:0]    i_rd_slot,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  logic [7:0] r_mem [NUM_SLOTS][DIGEST_BYTES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        for (int b = 0; b < DIGEST_BYTES; b++) begin
          r_mem[s][b] <= 8'h00;
        end
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_slot][i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = (int'(i_rd_slot) < NUM_SLOTS)
                   ? r_mem[i_rd_slot][i_rd_addr] : 8'h00;

endmodule

// File: rtl/digests_responder.sv
// GET_DIGESTS responder: header then one digest per provisioned slot.
// Define DIGESTS_ERR_RESP_EN to answer an empty slot mask with an ERROR frame.
module digests_responder
  import digests_responder_pkg::*;
#(
  parameter int         NUM_SLOTS    = 8,
  parameter int         DIGEST_BYTES = 32,
  parameter logic [7:0] PROTOCOL_VER = 8'h01,
  localparam int        AW           = $clog2(DIGEST_BYTES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [NUM_SLOTS-1:0] slots_provisioned,
  input  logic                 dig_wr_en,
  input  logic [2:0]           dig_wr_slot,
  input  logic [AW-1:0]        dig_wr_addr,
  input  logic [7:0]           dig_wr_data,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 tx_last,
  output logic                 busy,
  output logic                 Ack_out
);

  state_t               r_state;
  state_t               w_next;
  logic [NUM_SLOTS-1:0] r_mask;
  logic [1:0]           r_hdr;
  logic [2:0]           r_slot;
  logic [AW-1:0]        r_addr;

  logic [7:0] w_mask8;
  logic [3:0] w_first;
  logic [3:0] w_after;
  logic       w_zero;
  logic       w_err;
  logic       w_slot_end;
  logic       w_wr_en;
  logic [7:0] w_rd_data;

  assign w_mask8    = 8'(r_mask);
  assign w_first    = first_set_from(w_mask8, 4'd0);
  assign w_after    = first_set_from(w_mask8, {1'b0, r_slot} + 4'd1);
  assign w_zero     = w_first[3];
  assign w_slot_end = (r_addr == AW'(DIGEST_BYTES - 1));

`ifdef DIGESTS_ERR_RESP_EN
  assign w_err = w_zero;
`else
  assign w_err = 1'b0;
`endif

  assign busy      = (r_state != ST_IDLE);
  assign req_ready = (r_state == ST_IDLE);

  // Store is frozen for the whole frame, including the DONE cycle.
  assign w_wr_en = dig_wr_en && !busy
                && (int'(dig_wr_slot) < NUM_SLOTS);

  digest_store #(
    .NUM_SLOTS    (NUM_SLOTS),
    .DIGEST_BYTES (DIGEST_BYTES)
  ) u_store (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_slot (dig_wr_slot),
    .i_wr_addr (dig_wr_addr),
    .i_wr_data (dig_wr_data),
    .i_rd_slot (r_slot),
    .i_rd_addr (r_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    Ack_out  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) w_next = ST_HDR;
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        case (r_hdr)
          2'd0:    tx_data = PROTOCOL_VER;
          2'd1:    tx_data = w_err ? ERROR_CMD : DIGESTS_CMD;
          2'd2:    tx_data = w_err ? ERR_INVALID_REQUEST : 8'h00;
          default: tx_data = w_err ? 8'h00 : w_mask8;
        endcase
        tx_last = (r_hdr == 2'(HDR_LEN - 1)) && w_zero;
        if (tx_ready && (r_hdr == 2'(HDR_LEN - 1))) begin
          w_next = w_zero ? ST_DONE : ST_DIGEST;
        end
      end
      ST_DIGEST: begin
        tx_valid = 1'b1;
        tx_data  = w_rd_data;
        tx_last  = w_slot_end && w_after[3];
        if (tx_ready && tx_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        Ack_out = 1'b1;
        w_next  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '0;
      r_hdr  <= 2'd0;
      r_slot <= 3'd0;
      r_addr <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_mask <= slots_provisioned;
            r_hdr  <= 2'd0;
            r_slot <= 3'd0;
            r_addr <= '0;
          end
        end
        ST_HDR: begin
          if (tx_ready) begin
            r_hdr <= r_hdr + 2'd1;
            if (r_hdr == 2'(HDR_LEN - 1)) r_slot <= w_first[2:0];
          end
        end
        ST_DIGEST: begin
          if (tx_ready) begin
            if (w_slot_end) begin
              r_addr <= '0;
              r_slot <= w_after[2:0];
            end else begin
              r_addr <= r_addr + AW'(1);
            end
          end
        end
        ST_DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digests_responder.sv
// Scoreboard bench for digests_responder: expected bytes queued at request
// time, popped and compared as the DUT transfers them.
module tb_digests_responder;

  localparam int NS = 8;
  localparam int DB = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [NS-1:0] slots_provisioned = '0;
  logic          dig_wr_en = 1'b0;
  logic [2:0]    dig_wr_slot = 3'd0;
  logic [4:0]    dig_wr_addr = 5'd0;
  logic [7:0]    dig_wr_data = 8'h00;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          tx_last;
  logic          busy;
  logic          Ack_out;

  digests_responder #(
    .NUM_SLOTS    (NS),
    .DIGEST_BYTES (DB),
    .PROTOCOL_VER (8'h01)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .slots_provisioned (slots_provisioned),
    .dig_wr_en         (dig_wr_en),
    .dig_wr_slot       (dig_wr_slot),
    .dig_wr_addr       (dig_wr_addr),
    .dig_wr_data       (dig_wr_data),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .tx_last           (tx_last),
    .busy              (busy),
    .Ack_out           (Ack_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_bytes  = 0;
  int n_acks   = 0;
  int n_acc    = 0;
  int cyc      = 0;
  int last_cyc = 0;
  int ack_cyc  = 0;

  logic [8:0] exp_q[$];
  logic [7:0] mdl [NS][DB];

  logic [8:0] held;
  bit         stalled = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset) begin
      stalled = 0;
    end else begin
      if (stalled && tx_valid) begin
        n_checks++;
        if ({tx_last, tx_data} !== held) begin
          n_errors++;
          $display("FAIL stall_hold got %h want %h", {tx_last, tx_data}, held);
        end
      end
      if (tx_valid && tx_ready) begin
        logic [8:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_byte got %h want none", {tx_last, tx_data});
        end else begin
          e = exp_q.pop_front();
          if ({tx_last, tx_data} !== e) begin
            n_errors++;
            $display("FAIL byte%0d got {last,data}=%h want %h",
                     n_bytes, {tx_last, tx_data}, e);
          end
        end
        if (tx_last) last_cyc = cyc;
        n_bytes++;
      end
      stalled = tx_valid && !tx_ready;
      held    = {tx_last, tx_data};
    end
    if (Ack_out) n_acks++;
    if (req_valid && req_ready) n_acc++;
  end

  task automatic push_frame(input logic [7:0] m);
    logic       err;
    logic [8:0] t;
`ifdef DIGESTS_ERR_RESP_EN
    err = (m == 8'h00);
`else
    err = 1'b0;
`endif
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, err ? 8'h7F : 8'h01});
    exp_q.push_back({1'b0, err ? 8'h01 : 8'h00});
    exp_q.push_back({m == 8'h00, err ? 8'h00 : m});
    for (int s = 0; s < NS; s++) begin
      if (m[s]) begin
        for (int a = 0; a < DB; a++) exp_q.push_back({1'b0, mdl[s][a]});
      end
    end
    if (m != 8'h00) begin
      t = exp_q.pop_back();
      t[8] = 1'b1;
      exp_q.push_back(t);
    end
  endtask

  task automatic wr(input int s, input int a, input logic [7:0] d);
    dig_wr_en   = 1'b1;
    dig_wr_slot = 3'(s);
    dig_wr_addr = 5'(a);
    dig_wr_data = d;
    @(posedge clk); #1;
    dig_wr_en = 1'b0;
  endtask

  task automatic load_slots();
    for (int a = 0; a < DB; a++) begin
      wr(0, a, 8'(a));
      mdl[0][a] = 8'(a);
      wr(2, a, 8'(8'hA0 + a));
      mdl[2][a] = 8'(8'hA0 + a);
    end
  endtask

  task automatic start_req(input logic [7:0] m);
    slots_provisioned = m;
    push_frame(m);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_ack(input int budget, input bit toggle, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (Ack_out) begin
        ok = 1;
        ack_cyc = cyc;
        break;
      end
      if (toggle) begin
        @(posedge clk); #1;
        tx_ready = ~tx_ready;
      end
    end
    if (!ok) begin
      n_errors++;
      $display("FAIL ack_timeout got none want Ack_out within %0d cycles", budget);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({tx_valid, tx_last, busy, Ack_out, req_ready} !== 5'b00001) begin
      n_errors++;
      $display("FAIL reset_ctrl got %b want 00001",
               {tx_valid, tx_last, busy, Ack_out, req_ready});
    end
    n_checks++;
    if (tx_data !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_data got %h want 00", tx_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int base;
    bit ok;
    load_slots();
    base = n_bytes;
    start_req(8'h05);
    wait_ack(1000, 0, ok);
    n_checks++;
    if (n_bytes - base != 68) begin
      n_errors++;
      $display("FAIL basic_len got %0d want 68", n_bytes - base);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL basic_left got %0d want 0", exp_q.size());
    end
    n_checks++;
    if (ack_cyc != last_cyc + 1) begin
      n_errors++;
      $display("FAIL ack_timing got %0d want %0d", ack_cyc, last_cyc + 1);
    end
    @(negedge clk);
    n_checks++;
    if ({Ack_out, req_ready, busy} !== 3'b010) begin
      n_errors++;
      $display("FAIL ack_pulse got %b want 010", {Ack_out, req_ready, busy});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int base;
    bit ok;
    base = n_bytes;
    start_req(8'h05);
    wait_ack(1000, 1, ok);
    n_checks++;
    if (n_bytes - base != 68 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL bp_len got %0d/%0d want 68/0", n_bytes - base, exp_q.size());
    end
  endtask

  task automatic test_zero_mask();
    int base;
    bit ok;
    base = n_bytes;
    start_req(8'h00);
    wait_ack(100, 0, ok);
    n_checks++;
    if (n_bytes - base != 4 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL zero_len got %0d/%0d want 4/0", n_bytes - base, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    base = n_bytes;
    start_req(8'h05);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (n_bytes - base >= 20) break;
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({tx_valid, busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL mid_reset got %b want 00 (bytes=%0d)", {tx_valid, busy}, n_bytes - base);
    end
    exp_q.delete();
    for (int s = 0; s < NS; s++)
      for (int a = 0; a < DB; a++) mdl[s][a] = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    start_req(8'h05);
    wait_ack(1000, 0, ok);
    load_slots();
    base = n_bytes;
    start_req(8'h05);
    wait_ack(1000, 0, ok);
    n_checks++;
    if (n_bytes - base != 68 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL post_reset got %0d/%0d want 68/0", n_bytes - base, exp_q.size());
    end
  endtask

  task automatic test_frozen();
    bit ok;
    start_req(8'h05);
    repeat (3) @(posedge clk);
    #1 slots_provisioned = 8'hFF;
    wr(0, 0, 8'hFF);
    wait_ack(1000, 0, ok);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL frozen_left got %0d want 0", exp_q.size());
    end
    start_req(8'hFF);
    wait_ack(2000, 0, ok);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL frozen_next got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    int c0;
    bit ok;
    slots_provisioned = 8'h05;
    for (int k = 0; k < 3; k++) push_frame(8'h05);
    a0 = n_acks;
    c0 = n_acc;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) wait_ack(1000, 0, ok);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (n_acks - a0 != 3 || n_acc - c0 != 3) begin
      n_errors++;
      $display("FAIL b2b_count got acks=%0d acc=%0d want 3/3", n_acks - a0, n_acc - c0);
    end
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_left got %0d busy=%b want 0 busy=0", exp_q.size(), busy);
    end
  endtask

  initial begin
    for (int s = 0; s < NS; s++)
      for (int a = 0; a < DB; a++) mdl[s][a] = 8'h00;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_mask();
    test_reset_mid();
    test_frozen();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
